syzygy_dac_nco: RTL and testbench

SYZYGY_DAC_NCO -- requirements
Module: syzygy_dac_nco

---
 rtl/syzygy_dac_nco.sv | 102 ++++++++++
 tb/tb_syzygy_dac_nco.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/syzygy_dac_nco.sv
// ---------------------------------------------------------------------------
// syzygy_dac_nco
//   Numerically controlled oscillator that feeds an offset-binary DAC from an
//   external quarter-wave sine ROM. It has five stages:
//     S0 step    = freq_inc + inc_delta (mod 2^28)
//     S1 phase   = phase + step (mod 2^28), or 0 on phase_clr
//     S2 rom_addr from phase[25:16], mirrored in odd quadrants
//     S3 external ROM returns rom_data
//     S4 dac_data = 0x800 +/- magnitude, with the sign taken from the quadrant
//
// Ports
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous active-high reset
//   dis        in   1   synchronous output disable (level)
//   phase_clr  in   1   one-cycle pulse that zeroes the accumulator
//   freq_inc   in  28   unsigned carrier increment per clock
//   inc_delta  in  28   signed FM offset added to freq_inc
//   rom_addr   out 10   quarter-wave ROM address (registered)
//   rom_data   in  11   ROM magnitude, valid one cycle after rom_addr
//   dac_data   out 12   offset-binary DAC sample (registered)
//   dac_valid  out  1   dac_data is derived from live phase
// ---------------------------------------------------------------------------
module syzygy_dac_nco (
    input  logic        clk,
    input  logic        reset,
    input  logic        dis,
    input  logic        phase_clr,
    input  logic [27:0] freq_inc,
    input  logic [27:0] inc_delta,
    output logic [9:0]  rom_addr,
    input  logic [10:0] rom_data,
    output logic [11:0] dac_data,
    output logic        dac_valid
);

    logic [27:0] step_q,  step_d;
    logic [27:0] phase_q, phase_d;
    logic [1:0]  quad1_q, quad1_d;   // quadrant travelling alongside rom_addr
    logic [1:0]  quad2_q, quad2_d;   // quadrant aligned with rom_data
    logic [9:0]  addr_q,  addr_d;
    logic [11:0] dac_q,   dac_d;
    logic [3:0]  vld_q,   vld_d;

    logic [1:0]  quad;
    logic [9:0]  idx;

    assign quad = phase_q[27:26];
    assign idx  = phase_q[25:16];

    always_comb begin
        // The signed offset is added in two's complement, so a plain
        // 28-bit sum wraps correctly in both directions.
        step_d  = freq_inc + inc_delta;
        phase_d = phase_clr ? 28'h0 : phase_q + step_q;
        // The quarter-wave table is read backwards in quadrants 1 and 3.
        addr_d  = quad[0] ? ~idx : idx;
        quad1_d = quad;
        quad2_d = quad1_q;
        // The lower half-wave is mirrored around mid-scale.
        // 0x7FF - m and 0x800 + m both stay inside 12 bits for m <= 2047.
        dac_d   = quad2_q[1] ? (12'h7FF - {1'b0, rom_data})
                             : (12'h800 + {1'b0, rom_data});
        vld_d   = {vld_q[2:0], 1'b1};

        // dis takes priority over phase_clr. Because it flushes the whole
        // pipe, the phase restarts from 0 when dis is dropped.
        if (dis) begin
            step_d  = 28'h0;
            phase_d = 28'h0;
            addr_d  = 10'h0;
            quad1_d = 2'b00;
            quad2_d = 2'b00;
            dac_d   = 12'h800;
            vld_d   = 4'h0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_q  <= 28'h0;
            phase_q <= 28'h0;
            quad1_q <= 2'b00;
            quad2_q <= 2'b00;
            addr_q  <= 10'h0;
            dac_q   <= 12'h800;
            vld_q   <= 4'h0;
        end else begin
            step_q  <= step_d;
            phase_q <= phase_d;
            quad1_q <= quad1_d;
            quad2_q <= quad2_d;
            addr_q  <= addr_d;
            dac_q   <= dac_d;
            vld_q   <= vld_d;
        end
    end

    assign rom_addr  = addr_q;
    assign dac_data  = dac_q;
    assign dac_valid = vld_q[3];

endmodule

// File: tb/tb_syzygy_dac_nco.sv
// ---------------------------------------------------------------------------
// tb_syzygy_dac_nco
//   Self-checking bench for syzygy_dac_nco. A stub ROM with selectable
//   contents drives rom_data. The reference model tracks the phase after
//   each edge and derives the expected address and sample from that phase
//   history.
// ---------------------------------------------------------------------------
module tb_syzygy_dac_nco;

    logic        clk = 1'b0;
    logic        rst;
    logic        dis;
    logic        clr;
    logic [27:0] freq;
    logic [27:0] delta;
    logic [9:0]  rom_addr;
    logic [10:0] rom_data;
    logic [11:0] dac_data;
    logic        dac_valid;

    int          mode;          // 0: address pattern, 1: all 2047, 2: all 0
    int          n_chk  = 0;
    int          n_pass = 0;

    // Reference model state
    logic [27:0] m_step, m_phase, ph1, ph2, ph3;
    int          m_vcnt;
    logic [9:0]  exp_addr;
    logic [11:0] exp_dac;
    logic        exp_valid;
    logic        exp_forced;    // dis or reset was active at this edge

    syzygy_dac_nco dut (
        .clk       (clk),
        .reset     (rst),
        .dis       (dis),
        .phase_clr (clr),
        .freq_inc  (freq),
        .inc_delta (delta),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .dac_data  (dac_data),
        .dac_valid (dac_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] rom_f(input logic [9:0] a, input int md);
        case (md)
            1:       return 11'd2047;
            2:       return 11'd0;
            default: return {a, a[9]};
        endcase
    endfunction

    // Stub external ROM: the data is registered one cycle after the address.
    always @(posedge clk) rom_data <= rom_f(rom_addr, mode);

    function automatic logic [9:0] addr_of(input logic [27:0] p);
        int q, i;
        q = int'(p[27:26]);
        i = int'(p[25:16]);
        return (q % 2 == 1) ? 10'(1023 - i) : 10'(i);
    endfunction

    function automatic logic [11:0] dac_of(input logic [27:0] p, input int md);
        int q, mag;
        q   = int'(p[27:26]);
        mag = int'(rom_f(addr_of(p), md));
        return (q >= 2) ? 12'(2047 - mag) : 12'(2048 + mag);
    endfunction

    task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // Advance the model by one rising edge, using the inputs held across it.
    task automatic model_edge();
        logic [27:0] np;
        exp_forced = rst || dis;
        if (exp_forced) begin
            m_step = 28'h0;
            np     = 28'h0;
            m_vcnt = 0;
        end else begin
            np     = clr ? 28'h0 : m_phase + m_step;
            m_step = freq + delta;
            if (m_vcnt < 4) m_vcnt++;
        end
        ph3 = ph2; ph2 = ph1; ph1 = m_phase; m_phase = np;
        exp_addr  = exp_forced ? 10'h0 : addr_of(ph1);
        exp_dac   = exp_forced ? 12'h800 : dac_of(ph3, mode);
        exp_valid = (m_vcnt >= 4);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("rom_addr", 28'(rom_addr), 28'(exp_addr));
        chk("dac_valid", 28'(dac_valid), 28'(exp_valid));
        if (exp_forced || exp_valid)
            chk("dac_data", 28'(dac_data), 28'(exp_dac));
    endtask

    initial begin
        rst = 1'b1; dis = 1'b0; clr = 1'b0; freq = 28'h0; delta = 28'h0; mode = 0;
        m_step = 0; m_phase = 0; ph1 = 0; ph2 = 0; ph3 = 0; m_vcnt = 0;

        // The outputs are at their reset state before the first edge.
        #2;
        chk("rst_addr", 28'(rom_addr), 28'h0);
        chk("rst_dac", 28'(dac_data), 28'h800);
        chk("rst_valid", 28'(dac_valid), 28'h0);
        tick(); tick();

        // Carrier of 1 ROM step per clock. This sweeps all four quadrants
        // and the 28-bit wrap.
        freq = 28'h0010000;
        #4 rst = 1'b0;
        for (int e = 1; e <= 4200; e++) begin
            tick();
            if (e == 3)    chk("sweep_addr1", 28'(rom_addr), 28'd1);
            if (e == 3)    chk("sweep_valid3", 28'(dac_valid), 28'd0);
            if (e == 4)    chk("sweep_valid4", 28'(dac_valid), 28'd1);
            if (e == 4)    chk("sweep_addr2", 28'(rom_addr), 28'd2);
            if (e == 1026) chk("q1_addr1023", 28'(rom_addr), 28'd1023);
            if (e == 1027) chk("q1_addr1022", 28'(rom_addr), 28'd1022);
            if (e == 4098) chk("wrap_addr0", 28'(rom_addr), 28'd0);
            if (e == 4098) chk("wrap_valid", 28'(dac_valid), 28'd1);
        end

        // Randomized increments, FM offsets, phase clears and disable runs.
        for (int i = 0; i < 600; i++) begin
            freq  = 28'($urandom);
            delta = 28'($urandom);
            clr   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 19) == 0) dis = ~dis;
            tick();
        end
        clr = 1'b0;

        // A negative FM offset from phase 0 lands in quadrant 3 at address 0.
        dis = 1'b1; tick();
        dis = 1'b0; freq = 28'h0; delta = 28'hFFF0000;
        for (int e = 1; e <= 6; e++) begin
            tick();
            if (e == 3) chk("neg_addr0", 28'(rom_addr), 28'd0);
        end

        // Full-scale ROM: quadrants 0/1 give 0xFFF and quadrants 2/3 give 0x000.
        // A zero ROM in quadrants 2/3 gives 0x7FF.
        for (int md = 1; md <= 2; md++) begin
            dis = 1'b1; tick();
            mode = md;
            tick();
            dis = 1'b0; freq = 28'h4000000; delta = 28'h0;
            for (int e = 1; e <= 12; e++) begin
                tick();
                if (md == 1 && e == 4) chk("fs_q0", 28'(dac_data), 28'hFFF);
                if (md == 1 && e == 6) chk("fs_q2", 28'(dac_data), 28'h000);
                if (md == 2 && e == 6) chk("zero_q2", 28'(dac_data), 28'h7FF);
            end
        end
        dis = 1'b1; tick();
        mode = 0; tick();
        dis = 1'b0;

        // Raise dis with phase_clr in the same cycle mid-stream, then drop dis.
        freq = 28'h0123457; delta = 28'h0000F00;
        for (int e = 0; e < 10; e++) tick();
        dis = 1'b1; clr = 1'b1;
        tick();
        chk("dis_dac", 28'(dac_data), 28'h800);
        chk("dis_valid", 28'(dac_valid), 28'h0);
        clr = 1'b0; tick();
        dis = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 3) chk("redis_valid3", 28'(dac_valid), 28'd0);
            if (e == 4) chk("redis_valid4", 28'(dac_valid), 28'd1);
        end

        // A phase_clr pulse on its own leaves dac_valid high.
        clr = 1'b1; tick();
        chk("clr_keeps_valid", 28'(dac_valid), 28'd1);
        clr = 1'b0;
        for (int e = 0; e < 6; e++) tick();

        // Asynchronous reset mid-stream takes effect without a clock edge.
        #3 rst = 1'b1;
        #1;
        chk("async_addr", 28'(rom_addr), 28'h0);
        chk("async_dac", 28'(dac_data), 28'h800);
        chk("async_valid", 28'(dac_valid), 28'h0);
        tick(); tick();
        #4 rst = 1'b0;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 4) chk("rerst_valid4", 28'(dac_valid), 28'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
